i2c_slave_regbank: RTL

- Clock-synchronous I2C target with a parametrised bank of byte registers.
- Oversamples SCL/SDA in the system clock domain; no logic is clocked by SCL.
- Supports a register pointer with auto-increment, multi-byte write and read, repeated START, and master-NACK release.
- Sits at the board I2C pins and drives configuration/IO lines from its register bank.

---
 rtl/i2c_slave_regbank.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: I2C target with a bank of NUM_REGS byte registers, pointer auto-increment, repeated START.
// Latency: pins pass SYNC_STAGES sync flops plus an edge flop; sda_oe updates one clk after the synchronised SCL fall.
// Backpressure: none; the bus master owns SCL and this target never stretches the clock.
//
// Ports:
//   clk, rst_n        system clock (>= 8x SCL) and async active-low reset
//   scl_in, sda_in    raw pin levels, oversampled in the clk domain
//   sda_oe            1 = pull SDA low (open-drain pad)
//   regs_out          register bank, reg k at [8k+7:8k]
//   wr_pulse, wr_idx  one-clk strobe and register index for each committed data byte
//   busy              high from an address-matched START until STOP
//
// Optional build macro GENERAL_CALL_EN: ACK general call address 7'h00 (W) and treat data byte
// 8'h06 as a software reset of the bank and pointer.
module i2c_slave_regbank #(
  parameter logic [6:0] I2C_ADR     = 7'h27,
  parameter int         NUM_REGS    = 4,
  parameter logic [7:0] RESET_VAL   = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  wr_pulse,
  output logic [6:0]            wr_idx,
  output logic                  busy
);

  localparam int            PW    = $clog2(NUM_REGS);
  localparam logic [7:0]    NREG8 = 8'(NUM_REGS);
  localparam logic [PW-1:0] LAST  = PW'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
  } state_t;

  // ---------------- input conditioning ----------------
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda;
  logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

  // Sync chains reset to the idle-bus level so reset release cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise =  w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl &  r_scl_d;
  // START/STOP need SCL high on both samples, so they can never share a clk with an SCL edge;
  // the FSM still tests them first.
  assign w_start    = w_scl & r_scl_d &  r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d &  w_sda;

  // ---------------- state and datapath registers ----------------
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bit;
  logic          r_full;     // 8 bits received/sent; the next SCL fall enters the ACK slot
  logic [7:0]    r_shift;    // receive shifter, also holds the master ACK bit in RACK
  logic [6:0]    r_tx;       // remaining read bits, next bit to drive at [6]
  logic          r_rw;
  logic          r_gc;       // general-call transaction in progress
  logic [PW-1:0] r_ptr;
  logic [7:0]    r_regs [NUM_REGS];
  logic          r_sda_oe;
  logic          r_busy;
  logic          r_wr_pulse;
  logic [6:0]    r_wr_idx;

  logic [7:0]    w_rx_byte;
  logic [7:0]    w_rd_byte;
  logic          w_data_state;

  assign w_rx_byte    = {r_shift[6:0], w_sda};
  assign w_rd_byte    = r_regs[r_ptr];
  assign w_data_state = (r_state == S_ADDR)  || (r_state == S_PTR) ||
                        (r_state == S_WDATA) || (r_state == S_RDATA);

  // ---------------- FSM control ----------------
  logic w_oe_upd, w_oe_nxt, w_bit_clr, w_full_clr, w_rw_cap;
  logic w_load_tx, w_shift_tx, w_ptr_load, w_ptr_inc, w_wr_en;
  logic w_gc_rst, w_gc_set, w_gc_clr, w_busy_set, w_busy_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_oe_upd    = 1'b0;
    w_oe_nxt    = 1'b0;
    w_bit_clr   = 1'b0;
    w_full_clr  = 1'b0;
    w_rw_cap    = 1'b0;
    w_load_tx   = 1'b0;
    w_shift_tx  = 1'b0;
    w_ptr_load  = 1'b0;
    w_ptr_inc   = 1'b0;
    w_wr_en     = 1'b0;
    w_gc_rst    = 1'b0;
    w_gc_set    = 1'b0;
    w_gc_clr    = 1'b0;
    w_busy_set  = 1'b0;
    w_busy_clr  = 1'b0;

    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_oe_upd    = 1'b1;
      w_bit_clr   = 1'b1;
      w_full_clr  = 1'b1;
      w_gc_clr    = 1'b1;
      w_busy_clr  = 1'b1;
    end else if (w_start) begin
      // Repeated START keeps the pointer so a write of the pointer can precede a read.
      w_state_nxt = S_ADDR;
      w_oe_upd    = 1'b1;
      w_bit_clr   = 1'b1;
      w_full_clr  = 1'b1;
      w_gc_clr    = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;

        S_ADDR: begin
          if (w_scl_fall && r_full) begin
            w_full_clr = 1'b1;
            w_rw_cap   = 1'b1;
            w_oe_upd   = 1'b1;
            if (r_shift[7:1] == I2C_ADR) begin
              w_state_nxt = S_ADDR_ACK;
              w_oe_nxt    = 1'b1;
              w_busy_set  = 1'b1;
`ifdef GENERAL_CALL_EN
            end else if (r_shift == 8'h00) begin
              w_state_nxt = S_ADDR_ACK;
              w_oe_nxt    = 1'b1;
              w_gc_set    = 1'b1;
`endif
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end

        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_oe_upd  = 1'b1;
            w_bit_clr = 1'b1;
            if (r_rw) begin
              // Read: first data bit goes out as the ACK slot closes.
              w_state_nxt = S_RDATA;
              w_load_tx   = 1'b1;
              w_oe_nxt    = ~w_rd_byte[7];
            end else begin
              w_state_nxt = S_PTR;
            end
          end
        end

        S_PTR: begin
          if (w_scl_fall && r_full) begin
            w_full_clr = 1'b1;
            w_oe_upd   = 1'b1;
            if (r_gc) begin
              if (r_shift == 8'h06) begin
                w_state_nxt = S_PTR_ACK;
                w_oe_nxt    = 1'b1;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end else if (r_shift < NREG8) begin
              w_state_nxt = S_PTR_ACK;
              w_oe_nxt    = 1'b1;
              w_ptr_load  = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end

        S_PTR_ACK: begin
          if (w_scl_fall) begin
            w_oe_upd = 1'b1;
            if (r_gc) begin
              // General-call reset takes effect as the ACK slot of 8'h06 closes.
              w_gc_rst    = 1'b1;
              w_state_nxt = S_PTR;
            end else begin
              w_state_nxt = S_WDATA;
            end
          end
        end

        S_WDATA: begin
          if (w_scl_rise && (r_bit == 3'd7)) w_wr_en = 1'b1;
          if (w_scl_fall && r_full) begin
            w_full_clr  = 1'b1;
            w_state_nxt = S_WDATA_ACK;
            w_oe_upd    = 1'b1;
            w_oe_nxt    = 1'b1;
            w_ptr_inc   = 1'b1;
          end
        end

        S_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt = S_WDATA;
            w_oe_upd    = 1'b1;
          end
        end

        S_RDATA: begin
          if (w_scl_fall) begin
            w_oe_upd = 1'b1;
            if (r_full) begin
              // Byte done: release SDA for the master's ACK slot.
              w_full_clr  = 1'b1;
              w_state_nxt = S_RACK;
              w_ptr_inc   = 1'b1;
            end else begin
              w_oe_nxt   = ~r_tx[6];
              w_shift_tx = 1'b1;
            end
          end
        end

        S_RACK: begin
          if (w_scl_fall) begin
            w_oe_upd  = 1'b1;
            w_bit_clr = 1'b1;
            if (!r_shift[0]) begin
              w_state_nxt = S_RDATA;
              w_load_tx   = 1'b1;
              w_oe_nxt    = ~w_rd_byte[7];
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit      <= '0;
      r_full     <= 1'b0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_rw       <= 1'b0;
      r_gc       <= 1'b0;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_idx   <= '0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
    end else begin
      r_wr_pulse <= w_wr_en;
      if (w_wr_en) r_wr_idx <= 7'(r_ptr);

      if (w_bit_clr)                       r_bit <= '0;
      else if (w_scl_rise && w_data_state) r_bit <= r_bit + 3'd1;

      if (w_full_clr)                                          r_full <= 1'b0;
      else if (w_scl_rise && w_data_state && (r_bit == 3'd7)) r_full <= 1'b1;

      if (w_scl_rise && (r_state != S_IDLE)) r_shift <= w_rx_byte;

      if (w_rw_cap) r_rw <= r_shift[0];

      if (w_gc_set)      r_gc <= 1'b1;
      else if (w_gc_clr) r_gc <= 1'b0;

      if (w_oe_upd) r_sda_oe <= w_oe_nxt;

      if (w_busy_set)      r_busy <= 1'b1;
      else if (w_busy_clr) r_busy <= 1'b0;

      if (w_load_tx)       r_tx <= w_rd_byte[6:0];
      else if (w_shift_tx) r_tx <= {r_tx[5:0], 1'b0};

      if (w_gc_rst)        r_ptr <= '0;
      else if (w_ptr_load) r_ptr <= r_shift[PW-1:0];
      else if (w_ptr_inc)  r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;

      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_gc_rst)                                r_regs[k] <= RESET_VAL;
        else if (w_wr_en && (r_ptr == PW'(k)))       r_regs[k] <= w_rx_byte;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[8*g +: 8] = r_regs[g];
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign wr_pulse = r_wr_pulse;
  assign wr_idx   = r_wr_idx;

endmodule
